// File: rtl/fde_sequencer_pkg.sv
// fde_sequencer_pkg
// Shared definitions for the fetch/decode/execute sequencer: the sequencer
// state encoding and the default program-counter width and reset address.
// No ports; imported by fde_sequencer and fde_sequencer_pc_reg.
package fde_sequencer_pkg;

    localparam int unsigned PC_W_DEF     = 4;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_e;

endpackage

// File: rtl/fde_sequencer_pc_reg.sv
// fde_sequencer_pc_reg
// Program-counter register. Load takes priority over increment; increment
// wraps modulo 2^PC_W.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset, loads RESET_PC
//   ld_i   in   load tgt_i this cycle
//   inc_i  in   increment this cycle (ignored when ld_i is high)
//   tgt_i  in   load value
//   pc_o   out  current program counter
module fde_sequencer_pc_reg
    import fde_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_i,
    input  logic            inc_i,
    input  logic [PC_W-1:0] tgt_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ld_i) begin
            pc_d = tgt_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fde_sequencer.sv
// fde_sequencer
// Instruction sequencer stepping IDLE -> FETCH -> DECODE -> EXECUTE, with a
// sticky HALT state, single-step mode and branch/increment PC update.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   run          in   level: continuous execution request
//   step         in   pulse: execute one instruction from IDLE
//   halt_req     in   level: stop at the next EXECUTE boundary
//   imem_ready   in   instruction word for pc is available
//   is_halt      in   decoded HLT, looked at only in DECODE
//   br_taken     in   branch taken, looked at only in EXECUTE
//   br_target    in   branch destination, used with br_taken
//   pc           out  current instruction address
//   fetch_en     out  high in FETCH
//   decode_en    out  high in DECODE
//   exec_en      out  high in EXECUTE
//   busy         out  high in FETCH, DECODE or EXECUTE
//   halted       out  high in HALT
//   stall        out  high in FETCH while imem_ready is low
//   state_dbg_o  out  current state, for observation
//
// Handshake: imem_ready is the only flow control. FETCH waits, with pc
// stable, for the cycle in which imem_ready is high and leaves on that edge;
// there is no back-pressure toward the instruction memory.
module fde_sequencer
    import fde_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    input  logic            halt_req,
    input  logic            imem_ready,
    input  logic            is_halt,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic            decode_en,
    output logic            exec_en,
    output logic            busy,
    output logic            halted,
    output logic            stall,
    output state_e          state_dbg_o
);

    state_e          state_q, state_d;
    logic            step_mode_q, step_mode_d;
    logic            run_q;
    logic            pc_ld;
    logic            pc_inc;
    logic [PC_W-1:0] pc_tgt;

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        pc_ld       = 1'b0;
        pc_inc      = 1'b0;
        pc_tgt      = br_target;
        unique case (state_q)
            S_IDLE: begin
                // run wins over a simultaneous step: no single-step latch.
                if (run) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_halt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                pc_ld       = br_taken;
                pc_inc      = !br_taken;
                step_mode_d = 1'b0;
                if (step_mode_q || halt_req || !run) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                // Only a fresh rising edge of run restarts; a held run does not.
                if (run && !run_q) begin
                    state_d = S_FETCH;
                    pc_ld   = 1'b1;
                    pc_tgt  = RESET_PC;
                end
            end
            default: begin
                state_d     = S_IDLE;
                step_mode_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            run_q       <= run;
        end
    end

    fde_sequencer_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .ld_i  (pc_ld),
        .inc_i (pc_inc),
        .tgt_i (pc_tgt),
        .pc_o  (pc)
    );

    assign fetch_en    = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign exec_en     = (state_q == S_EXECUTE);
    assign busy        = fetch_en || decode_en || exec_en;
    assign halted      = (state_q == S_HALT);
    assign stall       = fetch_en && !imem_ready;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// tb_fde_sequencer
// Instruction-level stimulus with a PC reference model; expected retire/halt
// events are queued by the driver and consumed by a negedge monitor.
module tb_fde_sequencer;
    import fde_sequencer_pkg::*;

    localparam int              PC_W   = 4;
    localparam logic [PC_W-1:0] RST_PC = '0;
    localparam int              EW     = 1 + PC_W + 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            run, step, halt_req, imem_ready, is_halt, br_taken;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic            fetch_en, decode_en, exec_en, busy, halted, stall;
    state_e          state_dbg;

    // Entry: {is_halt_event, pc after event, stall cycles of the instruction}
    logic [EW-1:0]   exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    logic [PC_W-1:0] model_pc;

    fde_sequencer #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .imem_ready  (imem_ready),
        .is_halt     (is_halt),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .busy        (busy),
        .halted      (halted),
        .stall       (stall),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic            pend_ret    = 1'b0;
    logic            prev_halted = 1'b0;
    logic            prev_fd     = 1'b0;
    logic [PC_W-1:0] prev_pc     = '0;
    int              stall_cnt   = 0;

    task automatic pop_and_check(input logic kind);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got event kind=%0d pc=%0d, required no event", kind, pc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e[EW-1]);
            check(kind ? "halt_pc" : "retire_pc", pc, e[PC_W+7:8]);
            check("stall_cycles", stall_cnt, e[7:0]);
        end
        stall_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            pend_ret    = 1'b0;
            prev_halted = 1'b0;
            prev_fd     = 1'b0;
            stall_cnt   = 0;
        end else begin
            if (pend_ret) pop_and_check(1'b0);
            if (halted && !prev_halted) pop_and_check(1'b1);
            if (prev_fd && (fetch_en || decode_en)) check("pc_hold", pc, prev_pc);
            if (stall) stall_cnt++;
            check("one_hot", int'($countones({fetch_en, decode_en, exec_en, halted}) <= 1), 1);
            check("busy_decode", busy, fetch_en | decode_en | exec_en);
            check("stall_only_fetch", stall && !fetch_en, 0);
            pend_ret    = exec_en;
            prev_halted = halted;
            prev_fd     = fetch_en || decode_en;
            prev_pc     = pc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Noise on inputs that must be ignored in FETCH.
    task automatic noise_fetch();
        is_halt   = 1'($urandom_range(0, 1));
        br_taken  = 1'($urandom_range(0, 1));
        br_target = PC_W'($urandom);
        halt_req  = 1'($urandom_range(0, 1));
        step      = 1'($urandom_range(0, 1));
        run       = 1'($urandom_range(0, 1));
    endtask

    // Precondition: current cycle is FETCH. endm: 0 continue, 1 run low,
    // 2 halt_req high, 3 run kept high (single-step mode must stop).
    task automatic instr(input int s, input logic h, input logic bt,
                         input logic [PC_W-1:0] tgt, input int endm);
        check("fetch_en", fetch_en, 1);
        for (int i = 0; i < s; i++) begin
            imem_ready = 1'b0;
            noise_fetch();
            tick();
            check("fetch_held", fetch_en, 1);
        end
        imem_ready = 1'b1;
        noise_fetch();
        tick();
        check("decode_en", decode_en, 1);
        run        = 1'b1;
        is_halt    = h;
        imem_ready = 1'($urandom_range(0, 1));
        br_taken   = 1'($urandom_range(0, 1));
        br_target  = PC_W'($urandom);
        halt_req   = 1'($urandom_range(0, 1));
        step       = 1'($urandom_range(0, 1));
        if (h) begin
            exp_q.push_back({1'b1, model_pc, 8'(s)});
            tick();
            halt_req = 1'b0;
            is_halt  = 1'b0;
            check("halted", halted, 1);
            return;
        end
        tick();
        check("exec_en", exec_en, 1);
        is_halt    = 1'($urandom_range(0, 1));
        br_taken   = bt;
        br_target  = tgt;
        halt_req   = (endm == 2);
        run        = (endm != 1);
        imem_ready = 1'($urandom_range(0, 1));
        model_pc   = bt ? tgt : model_pc + PC_W'(1);
        exp_q.push_back({1'b0, model_pc, 8'(s)});
        tick();
        step     = 1'b0;
        halt_req = 1'b0;
        is_halt  = 1'b0;
        br_taken = 1'b0;
        if (endm != 0) begin
            check("back_to_idle", int'(state_dbg), int'(S_IDLE));
            run = 1'b0;
        end
    endtask

    task automatic start_run(input logic allow_step);
        run      = 1'b1;
        step     = allow_step ? 1'($urandom_range(0, 1)) : 1'b0;
        halt_req = 1'b0;
        tick();
        step = 1'b0;
    endtask

    task automatic start_step();
        run  = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // Precondition: current cycle is HALT with run held high.
    task automatic restart();
        run       = 1'b1;
        step      = 1'b1;
        br_taken  = 1'b1;
        br_target = PC_W'($urandom);
        tick();
        tick();
        step     = 1'b0;
        br_taken = 1'b0;
        check("halt_sticky", halted, 1);
        check("halt_pc_frozen", pc, model_pc);
        run = 1'b0;
        tick();
        check("halt_run_low", halted, 1);
        run = 1'b1;
        tick();
        check("restart_fetch", fetch_en, 1);
        check("restart_pc", pc, RST_PC);
        model_pc = RST_PC;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, pc, RST_PC);
        check({tag, "_state"}, int'(state_dbg), int'(S_IDLE));
        check({tag, "_outs"}, {fetch_en, decode_en, exec_en, busy, halted, stall}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        imem_ready = 1'b0; is_halt = 1'b0; br_taken = 1'b0; br_target = '0;
        model_pc = RST_PC;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        tick();
        check("idle_after_reset", busy, 0);

        // Sequential run with a 4-cycle stall on the first fetch.
        start_run(1'b0);
        instr(4, 1'b0, 1'b0, '0, 0);
        instr(0, 1'b0, 1'b0, '0, 0);
        instr(0, 1'b0, 1'b0, '0, 1);

        // Wrap from all-ones.
        start_run(1'b0);
        instr(0, 1'b0, 1'b1, 4'd15, 0);
        instr(0, 1'b0, 1'b0, '0, 2);

        // Branch 3 -> 9, halt at 9, restart at RESET_PC, branch to 5.
        start_run(1'b0);
        instr(0, 1'b0, 1'b1, 4'd3, 0);
        instr(1, 1'b0, 1'b1, 4'd9, 0);
        instr(0, 1'b1, 1'b0, '0, 0);
        restart();
        instr(0, 1'b0, 1'b1, 4'd5, 1);

        // Single step at pc=5 with run high at the EXECUTE boundary.
        start_step();
        instr(1, 1'b0, 1'b0, '0, 3);
        tick();
        check("step_stays_idle", busy, 0);
        check("step_pc", pc, 6);

        // Asynchronous reset in DECODE at pc=7.
        start_run(1'b0);
        instr(0, 1'b0, 1'b1, 4'd7, 1);
        run = 1'b1;
        tick();
        imem_ready = 1'b1;
        tick();
        check("pre_reset_decode", decode_en, 1);
        check("pre_reset_pc", pc, 7);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        run   = 1'b0;
        reset = 1'b1;
        model_pc = RST_PC;
        tick();
        check_all_zero("post_reset");

        // Randomized sequences.
        repeat (30) begin
            if ($urandom_range(0, 3) == 0) begin
                start_step();
                instr($urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)),
                      PC_W'($urandom), ($urandom_range(0, 1) == 0) ? 3 : 1);
                tick();
                check("rand_step_idle", busy, 0);
            end else begin
                int n, i, halts;
                logic h;
                n = $urandom_range(1, 5);
                i = 0;
                halts = 0;
                start_run(1'b1);
                while (i < n) begin
                    h = (halts < 2) && ($urandom_range(0, 7) == 0);
                    instr($urandom_range(0, 3), h, 1'($urandom_range(0, 1)), PC_W'($urandom),
                          (i == n - 1) ? int'($urandom_range(1, 2)) : 0);
                    if (h) begin
                        restart();
                        halts++;
                    end else begin
                        i++;
                    end
                end
            end
        end

        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
